// File: rtl/icache_pkg.sv
// Shared widths, constants and FSM state encodings for the instruction cache.
package icache_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam logic [InstBus-1:0] ZeroWord = '0;
  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_e;
endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: asynchronous read on index, synchronous write,
// single-cycle clear of every valid bit.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 7,
  parameter int TAG_W      = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] w_idx,
  input  logic [TAG_W-1:0]      w_tag,
  input  logic [InstBus-1:0]    w_data,
  input  logic [INDEX_BITS-1:0] r_idx,
  output logic                  r_valid,
  output logic [TAG_W-1:0]      r_tag,
  output logic [InstBus-1:0]    r_data
);
  localparam int Lines = 1 << INDEX_BITS;

  logic [Lines-1:0]   valid_reg;
  logic [TAG_W-1:0]   tag_mem  [Lines];
  logic [InstBus-1:0] data_mem [Lines];

  // Valid bits live in flops so a flush can clear them all at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (en) begin
      if (clear)
        valid_reg <= '0;
      else if (we)
        valid_reg[w_idx] <= True;
    end
  end

  always_ff @(posedge clk) begin
    if (en && we && !clear) begin
      tag_mem[w_idx]  <= w_tag;
      data_mem[w_idx] <= w_data;
    end
  end

  assign r_valid = valid_reg[r_idx];
  assign r_tag   = tag_mem[r_idx];
  assign r_data  = data_mem[r_idx];
endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and the
// memory controller instruction port, with PC redirect during a miss.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_pc,
  input  logic               flush,
  output logic               if_valid,
  output logic [InstBus-1:0] if_inst,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic               inst_fe,
  output logic [ADDR_W-1:0]  inst_fpc,
  input  logic               inst_ok,
  input  logic [InstBus-1:0] inst_o,
  input  logic [ADDR_W-1:0]  inst_pc
);
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  ic_state_e           state_reg;
  logic [ADDR_W-1:2]   miss_pc_reg;
  logic                if_valid_reg;

  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [InstBus-1:0]  rd_data;
  logic                hit;
  logic                fill_we;
  logic                redirect;
  logic                fill_match;

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (rdy),
    .clear   (flush),
    .we      (fill_we),
    .w_idx   (inst_pc[INDEX_BITS+1:2]),
    .w_tag   (inst_pc[ADDR_W-1:INDEX_BITS+2]),
    .w_data  (inst_o),
    .r_idx   (if_pc[INDEX_BITS+1:2]),
    .r_valid (rd_valid),
    .r_tag   (rd_tag),
    .r_data  (rd_data)
  );

  assign hit        = rd_valid && (rd_tag == if_pc[ADDR_W-1:INDEX_BITS+2]);
  // Any fill is written, even one for a PC that was redirected away from.
  assign fill_we    = (state_reg == IC_MISS) && inst_ok && !flush;
  assign redirect   = if_req && (if_pc[ADDR_W-1:2] != miss_pc_reg);
  assign fill_match = if_req && (inst_pc[ADDR_W-1:2] == if_pc[ADDR_W-1:2]);

  // A flush also suppresses a result already on the outputs this cycle.
  assign if_valid = if_valid_reg && !(flush && rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IC_IDLE;
      miss_pc_reg  <= '0;
      if_valid_reg <= False;
      if_inst      <= ZeroWord;
      if_pc_o      <= '0;
      inst_fe      <= False;
      inst_fpc     <= '0;
    end else if (rdy) begin
      if_valid_reg <= False;
      if (flush) begin
        state_reg <= IC_IDLE;
        inst_fe   <= False;
      end else begin
        case (state_reg)
          IC_IDLE: begin
            if (if_req) begin
              if (hit) begin
                if_valid_reg <= True;
                if_inst      <= rd_data;
                if_pc_o      <= if_pc;
              end else begin
                miss_pc_reg <= if_pc[ADDR_W-1:2];
                inst_fe     <= True;
                inst_fpc    <= if_pc;
                state_reg   <= IC_MISS;
              end
            end
          end
          IC_MISS: begin
            if (inst_ok) begin
              if (fill_match) begin
                if_valid_reg <= True;
                if_inst      <= inst_o;
                if_pc_o      <= inst_pc;
              end
              inst_fe   <= False;
              state_reg <= IC_IDLE;
            end else if (redirect) begin
              if (hit) begin
                if_valid_reg <= True;
                if_inst      <= rd_data;
                if_pc_o      <= if_pc;
                inst_fe      <= False;
                state_reg    <= IC_IDLE;
              end else begin
                miss_pc_reg <= if_pc[ADDR_W-1:2];
                inst_fpc    <= if_pc;
                inst_fe     <= True;
              end
            end else if (!if_req) begin
              inst_fe <= False;
            end
          end
          default: state_reg <= IC_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller's instruction port. Hits return an instruction one cycle after the request. On a miss the block drives `inst_fe`/`inst_fpc` until the controller pulses `inst_ok`, then fills the line and forwards the word. A PC redirect during a miss retargets the outstanding fetch.

## Interface
- `INDEX_BITS`, 7: line index width; the cache holds 2^INDEX_BITS words.
- `ADDR_W`, 32: PC width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable. When 0, all state and outputs hold.
- `if_req` in 1: IF stage requests the instruction at `if_pc`. Held until served or redirected.
- `if_pc` in ADDR_W: request PC, word-aligned; bits [1:0] are ignored.
- `flush` in 1: invalidate all lines (fence.i / reset of code space).
- `if_valid` out 1: one-cycle pulse; `if_inst`/`if_pc_o` are valid.
- `if_inst` out 32: instruction word.
- `if_pc_o` out ADDR_W: PC of `if_inst`.
- `inst_fe` out 1: fetch request to the memory controller.
- `inst_fpc` out ADDR_W: fetch address.
- `inst_ok` in 1: controller fill pulse.
- `inst_o` in 32: fill data.
- `inst_pc` in ADDR_W: fill address.

## Operation
- Index = `pc[INDEX_BITS+1:2]`. Tag = `pc[ADDR_W-1:INDEX_BITS+2]`. Each line has a valid bit, a tag and 32 data bits.
- States:
  - IDLE: when `if_req` is high, do a combinational lookup on `if_pc`.
    - Hit: register `if_valid`=1, `if_inst`, `if_pc_o`=`if_pc`. Stay in IDLE.
    - Miss: `miss_pc`<=`if_pc`, `inst_fe`<=1, `inst_fpc`<=`if_pc`, go to MISS.
  - MISS:
    - `inst_ok`=1: write the line at `inst_pc`'s index/tag, valid=1. This happens whether or not `inst_pc` equals `miss_pc`.
    - If `inst_ok`=1 and `inst_pc`==`if_pc` and `if_req`=1: `if_valid`<=1 with `inst_o`/`inst_pc`. Then `inst_fe`<=0 and go to IDLE.
    - If `inst_ok`=1 and `inst_pc`!=`if_pc`: `inst_fe`<=0 and go to IDLE. IDLE re-looks up next cycle.
    - `if_req`=1 and `if_pc`!=`miss_pc`, no `inst_ok`, new PC hits: serve the hit, `inst_fe`<=0, go to IDLE.
    - Same redirect case, new PC misses: `miss_pc`/`inst_fpc`<=`if_pc`, `inst_fe` stays 1. The controller restarts on the changed address.
    - `if_req`=0, no `inst_ok`: `inst_fe`<=0, stay in MISS. The controller's in-flight fetch still completes and is filled on `inst_ok`. If `if_req` reasserts with `if_pc`!=`miss_pc` before that `inst_ok`, treat it as the redirect cases above.
- `flush`=1: clear all valid bits in that cycle.
  - Drop any pending result: no `if_valid` this cycle or next.
  - Go to IDLE with `inst_fe`<=0.
  - Flush wins over a simultaneous `inst_ok`: the line is not written.

## Timing
- Reset values: `if_valid`=0, `if_inst`=0, `if_pc_o`=0, `inst_fe`=0, `inst_fpc`=0, all valid bits 0, state IDLE.
- Hit latency is 1 cycle: request at edge N, `if_valid` high in the cycle after edge N+1.
- `inst_fe` is registered. It is cleared on the same edge that samples `inst_ok`=1, so the controller, back in its idle state on the next edge, does not refetch.
- Miss latency = 1 cycle (`inst_fe` launch) + controller fetch (5 cycles after acceptance) + 1 cycle (fill/forward).
- Back-to-back: a hit can be served every cycle. After a fill, the next lookup starts the following cycle.
- `if_valid` is never high for two consecutive cycles for the same `if_pc_o` unless IF re-requests that PC.
- `rdy`=0 freezes the state register, the valid array, the data array and all outputs. Pulses are held rather than repeated.

## Structure
- Shared definitions header: `ZeroWord`, `True`/`False`, `InstAddrBus`/`InstBus` widths, and state encodings `IC_IDLE`/`IC_MISS`.
- One natural sub-module, `icache_array`:
  - valid/tag/data storage;
  - asynchronous read port on index;
  - synchronous write port;
  - single-cycle global valid clear.
- The controller FSM stays in `icache`.

## Test plan
- Cold miss: `if_pc`=0x0000_1000, controller model returns 0x0010_0093 after 5 cycles -> one `if_valid` pulse with `if_inst`=0x0010_0093, `if_pc_o`=0x1000; `inst_fe` high only until `inst_ok`.
- Re-request 0x1000 -> `if_valid` 1 cycle later, `inst_fe` stays 0.
- Conflict: fill 0x1000, then 0x1200 (same index when INDEX_BITS=7) -> second access misses; 0x1000 misses again afterwards.
- Redirect mid-miss: miss on 0x2000, change `if_pc` to 0x3000 two cycles later -> `inst_fpc`=0x3000; only 0x3000 is delivered; a late fill for 0x2000, if any, is written without `if_valid`.
- Flush after filling 0x1000 -> next request to 0x1000 misses; a flush coinciding with `inst_ok` leaves the line invalid.
- `rdy` low for 3 cycles mid-miss and async `rst_n` low mid-miss -> `rdy`: outputs frozen and the miss resumes. `rst_n`: all outputs 0, all lines invalid, state IDLE.
